// File: rtl/clk_enable_gen_pkg.sv
// Shared definitions for the clock-enable generator.
//   DIV_W_DEFAULT : default divisor width
//   DIV_DISABLED  : divisor value that parks a channel (no ce, no strobe)
//   ch_idx_w()    : width of a channel-index field; never collapses to 0 bits
package clk_enable_gen_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int DIV_DISABLED  = 0;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_enable_gen_channel.sv
// One divider channel of clk_enable_gen.
//   clk, rst_n  : clock, synchronous active-low reset
//   run         : low for the first cycle after reset; holds the counter at 0
//   wr_hit      : divisor write addressed to this channel
//   wr_data     : new divisor (0 disables the channel)
//   sync_req    : restart the counter at 0 and apply any pending divisor
//   ce          : single-cycle enable on the last count of each period
//   strobe      : high for the first ceil(N/2) counts of each period
//   done        : a full period has completed since the last change
//                 (forced high while the channel is disabled)
module clk_enable_gen_channel
    import clk_enable_gen_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr_hit,
    input  logic [DIV_W-1:0] wr_data,
    input  logic             sync_req,
    output logic             ce,
    output logic             strobe,
    output logic             done
);

    logic [DIV_W-1:0] active_div_reg;
    logic [DIV_W-1:0] pending_div_reg;
    logic             pending_vld_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic             done_reg;

    logic             disabled;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] half_cnt;
    logic             at_last;
    logic             boundary;
    logic             pending_vld_next;
    logic [DIV_W-1:0] pending_div_next;
    logic             apply;

    assign disabled = (active_div_reg == DIV_W'(DIV_DISABLED));
    assign last_cnt = active_div_reg - DIV_W'(1);
    // ceil(N/2) without widening: (N>>1) + N[0]
    assign half_cnt = (active_div_reg >> 1) + {{(DIV_W-1){1'b0}}, active_div_reg[0]};

    assign at_last  = run && !disabled && (cnt_reg == last_cnt);
    // A disabled channel has no period in flight, so every cycle is a boundary.
    assign boundary = disabled || at_last;

    // A write in the boundary/sync cycle is folded in here so it takes
    // effect at that same edge; a later write simply overwrites the slot.
    assign pending_vld_next = pending_vld_reg | wr_hit;
    assign pending_div_next = wr_hit ? wr_data : pending_div_reg;
    assign apply            = pending_vld_next && (sync_req || boundary);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_div_reg  <= RESET_DIV;
            pending_div_reg <= '0;
            pending_vld_reg <= 1'b0;
            cnt_reg         <= '0;
            done_reg        <= 1'b0;
        end else begin
            pending_div_reg <= pending_div_next;

            if (apply) begin
                active_div_reg  <= pending_div_next;
                pending_vld_reg <= 1'b0;
            end else begin
                pending_vld_reg <= pending_vld_next;
            end

            if (sync_req || boundary) begin
                cnt_reg <= '0;
            end else if (run) begin
                cnt_reg <= cnt_reg + DIV_W'(1);
            end

            // The ce that closes a period being replaced does not count
            // towards lock: lock needs a full period at the new divisor.
            if (sync_req || wr_hit || apply) begin
                done_reg <= 1'b0;
            end else if (at_last) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign ce     = at_last;
    assign strobe = run && !disabled && (cnt_reg < half_cnt);
    assign done   = done_reg | disabled;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator.
//   clk          : single clock for all logic
//   rst_n        : synchronous active-low reset
//   div_wr_en    : divisor write strobe
//   div_wr_ch    : target channel; indices >= NUM_CH are ignored
//   div_wr_data  : new divisor N (0 disables the channel)
//   sync_req     : restart all channels phase-aligned
//   ce[NUM_CH]   : one-cycle enable per period, per channel
//   strobe[NUM_CH]: near-50% duty divided waveform, per channel
//   locked       : every enabled channel has completed a full period
//                  since the last reset, sync or divisor write
// All outputs decode registered state only.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int                      NUM_CH     = 2,
    parameter int                      DIV_W      = DIV_W_DEFAULT,
    parameter logic [NUM_CH*DIV_W-1:0] RESET_DIVS = {16'd4, 16'd2}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          div_wr_en,
    input  logic [ch_idx_w(NUM_CH)-1:0]   div_wr_ch,
    input  logic [DIV_W-1:0]              div_wr_data,
    input  logic                          sync_req,
    output logic [NUM_CH-1:0]             ce,
    output logic [NUM_CH-1:0]             strobe,
    output logic                          locked
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    // Low for the reset cycles and the first cycle after release, so the
    // outputs stay quiet until the counters start from a clean 0.
    logic              run_reg;
    logic [NUM_CH-1:0] done_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

        logic wr_hit;
        assign wr_hit = div_wr_en && (div_wr_ch == CH_IDX);

        clk_enable_gen_channel #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIVS[gi*DIV_W +: DIV_W])
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run_reg),
            .wr_hit   (wr_hit),
            .wr_data  (div_wr_data),
            .sync_req (sync_req),
            .ce       (ce[gi]),
            .strobe   (strobe[gi]),
            .done     (done_vec[gi])
        );
    end

    assign locked = run_reg & (&done_vec);

endmodule
